// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight instruction tracker for the 5-stage RV32 core.
// It holds one slot per stage (EXE, MEM, WB) with {valid, write-enable, rd, optype}.
// The hazard detection unit's EN/flush signals advance, hold or bubble each slot.
// The unit reports effective destination registers, optypes, a pending-write mask
// and a load-in-flight flag.
// Optional feature: define HAZARD_SCOREBOARD_STALL_CNT_EN to build a saturating
// stall-cycle counter on stall_cnt. Without it, stall_cnt is tied to zero.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_ID,
  input  logic [REG_AW-1:0]         rd_ID,
  input  logic                      regwrite_ID,
  input  logic [1:0]                optype_ID,
  input  logic                      reg_DE_EN,
  input  logic                      reg_DE_flush,
  input  logic                      reg_EM_EN,
  input  logic                      reg_EM_flush,
  input  logic                      reg_MW_EN,
  input  logic                      reg_FD_stall,
  output logic [REG_AW-1:0]         rd_EXE,
  output logic [REG_AW-1:0]         rd_MEM,
  output logic [REG_AW-1:0]         rd_WB,
  output logic [1:0]                hazard_optype_ctrl_before1,
  output logic [1:0]                hazard_optype_ctrl_before2,
  output logic [1:0]                hazard_optype_ctrl_before3,
  output logic [(1<<REG_AW)-1:0]    pending_mask,
  output logic                      load_pending,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [1:0]        op;
  } slot_t;

  localparam slot_t BUBBLE = '{v: 1'b0, we: 1'b0, rd: '0, op: 2'b00};

  slot_t id_entry;
  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  // A bubble in ID can never carry a write enable into the pipeline.
  assign id_entry = '{v: valid_ID, we: valid_ID & regwrite_ID, rd: rd_ID, op: optype_ID};

  // Next-state for all three slots from pre-edge state; flush has priority over EN.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (reg_DE_flush)   exe_d = BUBBLE;
    else if (reg_DE_EN) exe_d = id_entry;
    if (reg_EM_flush)   mem_d = BUBBLE;
    else if (reg_EM_EN) mem_d = exe_q;
    if (reg_MW_EN)      wb_d  = mem_q;
  end

  // Slot registers; reset discards every in-flight entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Effective rd is zero unless the slot really writes, so x0 and non-writers look alike.
  assign rd_EXE = (exe_q.v & exe_q.we) ? exe_q.rd : '0;
  assign rd_MEM = (mem_q.v & mem_q.we) ? mem_q.rd : '0;
  assign rd_WB  = (wb_q.v  & wb_q.we)  ? wb_q.rd  : '0;

  assign hazard_optype_ctrl_before1 = exe_q.v ? exe_q.op : 2'b00;
  assign hazard_optype_ctrl_before2 = mem_q.v ? mem_q.op : 2'b00;
  assign hazard_optype_ctrl_before3 = wb_q.v  ? wb_q.op  : 2'b00;

  assign load_pending = (hazard_optype_ctrl_before1 == OP_LOAD) |
                        (hazard_optype_ctrl_before2 == OP_LOAD);

  // Decode of the effective rds; bit 0 stays clear because x0 is never a real hazard.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
      if (gi == 0) begin : g_x0
        assign pending_mask[gi] = 1'b0;
      end else begin : g_reg
        localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
        assign pending_mask[gi] = (rd_EXE == IDX) | (rd_MEM == IDX) | (rd_WB == IDX);
      end
    end
  endgenerate

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles; parks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (reg_FD_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = reg_FD_stall;
  assign stall_cnt    = '0;
`endif

endmodule
